// File: rtl/result_scanner.sv
// result_scanner
// Purpose: once the processor raises f_done, walk the result frame in the data
// RAM in row-major order and hand each pixel to a consumer through a
// valid/ready handshake. Each pixel takes three states: READ (issue a one-cycle
// read), WAIT (capture the RAM data) and PRESENT (hold until the consumer takes it).
//
// Ports:
//   clk        in   system clock, rising edge only
//   rst        in   synchronous active-high reset
//   f_done     in   processor-finished level; its rising edge starts a scan
//   mem_addr   out  [13:0] data-RAM read address
//   mem_rd_en  out  RAM read strobe, high for exactly one cycle per pixel
//   mem_data   in   [31:0] RAM read data, valid the cycle after mem_rd_en
//   px_data    out  [7:0] pixel value (mem_data[7:0])
//   px_valid   out  px_data/px_row/px_col are valid
//   px_ready   in   consumer accepts the pixel
//   px_row     out  [6:0] row index of the presented pixel
//   px_col     out  [6:0] column index of the presented pixel
//   busy       out  scan in progress (READ, WAIT, PRESENT)
//   scan_done  out  frame fully delivered, held until f_done drops

module result_scanner #(
    parameter int unsigned COLS = 100,
    parameter int unsigned ROWS = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_done,
    output logic [13:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [31:0] mem_data,
    output logic [7:0]  px_data,
    output logic        px_valid,
    input  logic        px_ready,
    output logic [6:0]  px_row,
    output logic [6:0]  px_col,
    output logic        busy,
    output logic        scan_done
);

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned IDX_W  = 7;
    localparam int unsigned PX_W   = 8;

    localparam logic [IDX_W-1:0]  COL_LAST = IDX_W'(COLS - 1);
    localparam logic [IDX_W-1:0]  ROW_LAST = IDX_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(COLS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_row;
    logic [IDX_W-1:0]   r_col;
    logic [ADDR_W-1:0]  r_row_base;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_mem_rd_en;
    logic [PX_W-1:0]    r_px_data;
    logic               r_px_valid;
    logic               r_busy;
    logic               r_scan_done;
    logic               r_f_done_q;
    // Set once f_done has been seen low after reset, so a level that is
    // already high when reset releases cannot masquerade as a rising edge.
    logic               r_armed;

    logic               w_start;
    logic               w_xfer;
    logic               w_unused_hi;

    assign w_start     = f_done & ~r_f_done_q & r_armed;
    assign w_xfer      = r_px_valid & px_ready;
    assign w_unused_hi = ^mem_data[31:PX_W];

    // Scan FSM; every output is a register updated on the state transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_row_base  <= '0;
            r_mem_addr  <= '0;
            r_mem_rd_en <= 1'b0;
            r_px_data   <= '0;
            r_px_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_scan_done <= 1'b0;
            r_f_done_q  <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_f_done_q <= f_done;
            if (!f_done) begin
                r_armed <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state     <= S_READ;
                        r_row       <= '0;
                        r_col       <= '0;
                        r_row_base  <= '0;
                        r_mem_addr  <= '0;
                        r_mem_rd_en <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end

                S_READ: begin
                    r_mem_rd_en <= 1'b0;
                    r_state     <= S_WAIT;
                end

                S_WAIT: begin
                    r_px_data  <= mem_data[PX_W-1:0];
                    r_px_valid <= 1'b1;
                    r_state    <= S_PRESENT;
                end

                S_PRESENT: begin
                    if (w_xfer) begin
                        r_px_valid <= 1'b0;
                        if (r_col != COL_LAST) begin
                            // Next column in the same row.
                            r_col       <= r_col + IDX_W'(1);
                            r_mem_addr  <= r_row_base + ADDR_W'(r_col) + ADDR_W'(1);
                            r_mem_rd_en <= 1'b1;
                            r_state     <= S_READ;
                        end else if (r_row != ROW_LAST) begin
                            // Row wrap: row_base steps by COLS, no multiplier.
                            r_col       <= '0;
                            r_row       <= r_row + IDX_W'(1);
                            r_row_base  <= r_row_base + ROW_STEP;
                            r_mem_addr  <= r_row_base + ROW_STEP;
                            r_mem_rd_en <= 1'b1;
                            r_state     <= S_READ;
                        end else begin
                            r_busy      <= 1'b0;
                            r_scan_done <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    if (!f_done) begin
                        r_scan_done <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_mem_rd_en <= 1'b0;
                    r_px_valid  <= 1'b0;
                    r_busy      <= 1'b0;
                    r_scan_done <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_rd_en = r_mem_rd_en;
    assign px_data   = r_px_data;
    assign px_valid  = r_px_valid;
    assign px_row    = r_row;
    assign px_col    = r_col;
    assign busy      = r_busy;
    assign scan_done = r_scan_done;

endmodule

// File: tb/tb_result_scanner.sv
// tb_result_scanner
// Purpose: directed bench for result_scanner. A 4x3 instance covers ordering,
// latency, stall, ignored restarts and mid-scan reset; a default-size 100x100
// instance covers the full-frame boundary. RAM models return RAM[a] = a.

module tb_result_scanner;

    typedef struct packed {
        logic [7:0] data;
        logic [6:0] row;
        logic [6:0] col;
    } pix_t;

    logic clk;
    logic rst;

    // Small 4x3 instance
    logic        s_f_done;
    logic [13:0] s_mem_addr;
    logic        s_mem_rd_en;
    logic [31:0] s_mem_data;
    logic [7:0]  s_px_data;
    logic        s_px_valid;
    logic        s_px_ready;
    logic [6:0]  s_px_row;
    logic [6:0]  s_px_col;
    logic        s_busy;
    logic        s_scan_done;

    // Default 100x100 instance
    logic        b_f_done;
    logic [13:0] b_mem_addr;
    logic        b_mem_rd_en;
    logic [31:0] b_mem_data;
    logic [7:0]  b_px_data;
    logic        b_px_valid;
    logic        b_px_ready;
    logic [6:0]  b_px_row;
    logic [6:0]  b_px_col;
    logic        b_busy;
    logic        b_scan_done;

    int   errors;
    int   checks;
    pix_t sb[$];
    int   aq[$];

    int   b_pix;
    int   b_addr;
    int   b_last_addr;
    int   b_cyc;

    result_scanner #(.COLS(4), .ROWS(3)) u_small (
        .clk       (clk),
        .rst       (rst),
        .f_done    (s_f_done),
        .mem_addr  (s_mem_addr),
        .mem_rd_en (s_mem_rd_en),
        .mem_data  (s_mem_data),
        .px_data   (s_px_data),
        .px_valid  (s_px_valid),
        .px_ready  (s_px_ready),
        .px_row    (s_px_row),
        .px_col    (s_px_col),
        .busy      (s_busy),
        .scan_done (s_scan_done)
    );

    result_scanner u_big (
        .clk       (clk),
        .rst       (rst),
        .f_done    (b_f_done),
        .mem_addr  (b_mem_addr),
        .mem_rd_en (b_mem_rd_en),
        .mem_data  (b_mem_data),
        .px_data   (b_px_data),
        .px_valid  (b_px_valid),
        .px_ready  (b_px_ready),
        .px_row    (b_px_row),
        .px_col    (b_px_col),
        .busy      (b_busy),
        .scan_done (b_scan_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous RAMs holding RAM[a] = a
    initial s_mem_data = '0;
    initial b_mem_data = '0;
    always @(posedge clk) if (s_mem_rd_en) s_mem_data <= 32'(s_mem_addr);
    always @(posedge clk) if (b_mem_rd_en) b_mem_data <= 32'(b_mem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_small_reset(input string tag);
        check({tag, "_addr"},  32'(s_mem_addr), 0);
        check({tag, "_rd"},    32'(s_mem_rd_en), 0);
        check({tag, "_data"},  32'(s_px_data), 0);
        check({tag, "_valid"}, 32'(s_px_valid), 0);
        check({tag, "_row"},   32'(s_px_row), 0);
        check({tag, "_col"},   32'(s_px_col), 0);
        check({tag, "_busy"},  32'(s_busy), 0);
        check({tag, "_done"},  32'(s_scan_done), 0);
    endtask

    function automatic void push_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back('{data: 8'(i), row: 7'(i / 4), col: 7'(i % 4)});
            aq.push_back(i);
        end
    endfunction

    // Raise f_done (caller is at a negedge with f_done low) and consume n_pix
    // transfers, checking reads against aq and pixels against sb.
    task automatic run_scan(input int n_pix, input int stall_idx, input int stall_len,
                            input bit extra_edge, input bit chk_timing);
        int   idx;
        int   cyc;
        int   stalled;
        pix_t exp_p;
        idx        = 0;
        cyc        = 0;
        stalled    = 0;
        s_px_ready = 1'b1;
        s_f_done   = 1'b1;
        while (idx < n_pix && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (extra_edge) s_f_done = !(idx >= 3 && idx < 5);
            if (s_mem_rd_en) begin
                if (aq.size() == 0) check("unexpected_read", 1, 0);
                else check("mem_addr", 32'(s_mem_addr), aq.pop_front());
            end
            if (s_px_valid) begin
                if (sb.size() == 0) begin
                    check("extra_pixel", 1, 0);
                    idx = n_pix;
                end else if (idx == stall_idx && stalled < stall_len) begin
                    exp_p      = sb[0];
                    s_px_ready = 1'b0;
                    stalled++;
                    check("stall_data",  32'(s_px_data), 32'(exp_p.data));
                    check("stall_row",   32'(s_px_row),  32'(exp_p.row));
                    check("stall_col",   32'(s_px_col),  32'(exp_p.col));
                    check("stall_no_rd", 32'(s_mem_rd_en), 0);
                end else begin
                    s_px_ready = 1'b1;
                    exp_p = sb.pop_front();
                    check("px_data",    32'(s_px_data), 32'(exp_p.data));
                    check("px_row",     32'(s_px_row),  32'(exp_p.row));
                    check("px_col",     32'(s_px_col),  32'(exp_p.col));
                    check("busy_in_px", 32'(s_busy), 1);
                    check("done_early", 32'(s_scan_done), 0);
                    if (chk_timing) check("px_timing", 32'(cyc), 32'(3 * (idx + 1)));
                    idx++;
                end
            end
        end
        check("scan_timeout", 32'(idx), 32'(n_pix));
    endtask

    // After the last transfer: scan_done next cycle, held, cleared by f_done low.
    task automatic finish_scan();
        @(negedge clk);
        check("scan_done_rise", 32'(s_scan_done), 1);
        check("busy_after",     32'(s_busy), 0);
        check("no_rd_after",    32'(s_mem_rd_en), 0);
        repeat (3) @(negedge clk);
        check("scan_done_hold", 32'(s_scan_done), 1);
        check("addr_left",      32'(aq.size()), 0);
        check("pix_left",       32'(sb.size()), 0);
        s_f_done = 1'b0;
        @(negedge clk);
        check("scan_done_clr",  32'(s_scan_done), 0);
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        rst        = 1'b1;
        s_f_done   = 1'b1;
        s_px_ready = 1'b1;
        b_f_done   = 1'b0;
        b_px_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_small_reset("reset");

        // f_done high through reset release must not start a scan
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("hi_at_release_busy", 32'(s_busy), 0);
            check("hi_at_release_rd",   32'(s_mem_rd_en), 0);
        end
        s_f_done = 1'b0;
        repeat (2) @(negedge clk);

        // Basic frame with latency/throughput timing
        push_pixels(12);
        run_scan(12, -1, 0, 1'b0, 1'b1);
        finish_scan();
        @(negedge clk);

        // Consumer stall of 5 cycles on pixel (1,2)
        push_pixels(12);
        run_scan(12, 6, 5, 1'b0, 1'b0);
        finish_scan();
        @(negedge clk);

        // Second f_done edge while busy is ignored
        push_pixels(12);
        run_scan(12, -1, 0, 1'b1, 1'b0);
        finish_scan();
        @(negedge clk);

        // Reset in WAIT of pixel (0,2)
        push_pixels(2);
        run_scan(2, -1, 0, 1'b0, 1'b0);
        @(negedge clk);
        check("read_px2_rd",   32'(s_mem_rd_en), 1);
        check("read_px2_addr", 32'(s_mem_addr), 2);
        @(negedge clk);
        check("wait_px2_rd",    32'(s_mem_rd_en), 0);
        check("wait_px2_valid", 32'(s_px_valid), 0);
        rst = 1'b1;
        @(negedge clk);
        check_small_reset("mid_reset");
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_rd",    32'(s_mem_rd_en), 0);
            check("post_rst_valid", 32'(s_px_valid), 0);
        end
        s_f_done = 1'b0;
        repeat (2) @(negedge clk);
        push_pixels(12);
        run_scan(12, -1, 0, 1'b0, 1'b0);
        finish_scan();

        // Full default-size frame
        @(negedge clk);
        b_pix       = 0;
        b_addr      = 0;
        b_last_addr = -1;
        b_cyc       = 0;
        b_f_done    = 1'b1;
        while (b_pix < 10000 && b_cyc < 40000) begin
            @(negedge clk);
            b_cyc++;
            if (b_mem_rd_en) begin
                check("big_addr", 32'(b_mem_addr), 32'(b_addr));
                b_last_addr = int'(b_mem_addr);
                b_addr++;
            end
            if (b_px_valid) begin
                check("big_data", 32'(b_px_data), 32'(b_pix % 256));
                check("big_row",  32'(b_px_row),  32'(b_pix / 100));
                check("big_col",  32'(b_px_col),  32'(b_pix % 100));
                b_pix++;
            end
        end
        check("big_transfers", 32'(b_pix), 10000);
        check("big_last_addr", 32'(b_last_addr), 9999);
        @(negedge clk);
        check("big_done_rise", 32'(b_scan_done), 1);
        repeat (4) @(negedge clk);
        check("big_done_hold", 32'(b_scan_done), 1);
        check("big_no_rd",     32'(b_mem_rd_en), 0);
        b_f_done = 1'b0;
        @(negedge clk);
        check("big_done_clr",  32'(b_scan_done), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
